// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared types and constants for the video RAM arbiter.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package vram_arbiter_pkg;

    // Default geometry of the 8 KB video RAM.
    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    // Window of the 6502 bus that the decoder routes to the video RAM.
    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_LAST = 16'h9FFF;

    // Owner of the RAM port for one cycle; also used as the return tag.
    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_VGA  = 2'd1,
        SLOT_CPU  = 2'd2
    } slot_t;

    // True when a 16-bit CPU bus address falls inside the video RAM window.
    function automatic logic vram_hit(input logic [15:0] cpu_bus_addr);
        return (cpu_bus_addr >= VRAM_BASE) && (cpu_bus_addr <= VRAM_LAST);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: VGA fetch, CPU request/ack and video RAM port bundled together.
// Latency: n/a (wiring only).
// Backpressure: CPU side uses level req held until a one-cycle ack; VGA side has none.
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);
    // VGA fetch port
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;

    // CPU bus port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    // Video RAM port (synchronous read, one cycle)
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the RAM: everything around the arbiter.
    modport master (
        output vga_req, vga_addr,
        input  vga_data,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    // The arbiter itself.
    modport slave (
        input  vga_req, vga_addr,
        output vga_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: one RAM slot per cycle, VGA fetch has hard priority over CPU; optional stall counter via VRAM_ARB_STATS_EN.
// Latency: vga_data valid 3 cycles after vga_req; cpu_ack 3 cycles after cpu_req unstalled, +1 per coinciding vga_req.
// Backpressure: none toward VGA; CPU waits on level cpu_req until the one-cycle cpu_ack, one access outstanding at a time.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus,
    output logic          vga_overrun
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_count
`endif
);

    // Slot being driven onto the RAM this cycle, and the tag of the slot whose data returns now.
    slot_t             slot_q;
    slot_t             slot_d;
    slot_t             tag_q;
    logic              tag_we_q;

    // Registered RAM port and its next values.
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              we_q;
    logic              we_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    // Return-side registers.
    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_ack_q;

    // A CPU access may only start when none of its own is in slot, in return, or being acked.
    logic              cpu_elig;
    logic              vga_back_to_back;

    assign cpu_elig         = (slot_q != SLOT_CPU) && (tag_q != SLOT_CPU) && !cpu_ack_q;
    assign vga_back_to_back = bus.vga_req && (slot_q == SLOT_VGA);

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.vga_data  = vga_data_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;

    // Slot decision: VGA always wins; CPU takes the slot only when eligible; otherwise idle with address held.
    always_comb begin
        slot_d  = SLOT_IDLE;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        if (bus.vga_req) begin
            slot_d = SLOT_VGA;
            addr_d = bus.vga_addr;
        end else if (bus.cpu_req && cpu_elig) begin
            slot_d  = SLOT_CPU;
            addr_d  = bus.cpu_addr;
            we_d    = bus.cpu_we;
            wdata_d = bus.cpu_wdata;
        end
    end

    // Issue side: register the chosen slot and the RAM port; the tag trails the slot by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q   <= SLOT_IDLE;
            tag_q    <= SLOT_IDLE;
            tag_we_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            tag_q    <= slot_q;
            tag_we_q <= we_q;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Return side: route mem_rdata by tag; CPU writes still ack but leave cpu_rdata alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= (tag_q == SLOT_CPU);
            if (tag_q == SLOT_VGA) begin
                vga_data_q <= bus.mem_rdata;
            end
            if ((tag_q == SLOT_CPU) && !tag_we_q) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Sticky flag: a new fetch arrived while the previous fetch still owned the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_overrun <= 1'b0;
        end else if (vga_back_to_back) begin
            vga_overrun <= 1'b1;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic cpu_lost_slot;

    assign cpu_lost_slot = bus.vga_req && bus.cpu_req && cpu_elig;

    // Count edges where a CPU access that could have gone was pushed back by VGA; wraps at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (cpu_lost_slot) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus a randomized run against a slot-schedule reference model.
// Latency: n/a (testbench).
// Backpressure: the bench's CPU master holds cpu_req until its ack, may withdraw at random.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int N  = 1500;

    logic clk = 1'b0;
    logic reset;
    logic vga_overrun;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .vga_overrun (vga_overrun)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read video RAM with a backdoor write port for preloading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_dat;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_dat;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference contents of the RAM, advanced in slot order by the model.
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    // Scheduled events of the reference model, indexed by cycle of the random run.
    logic          ev_vga   [N+8];
    logic [DW-1:0] ev_vval  [N+8];
    logic          ev_ack   [N+8];
    logic          ev_rd    [N+8];
    logic [DW-1:0] ev_rdata [N+8];
    logic          ev_ovr   [N+8];
    int            ev_stall [N+8];
    logic          ev_slot  [N+8];
    logic [AW-1:0] ev_addr  [N+8];
    logic          ev_cpuwr [N+8];
    logic [DW-1:0] ev_wdata [N+8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_dat = d;
        shadow[a] = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.vga_data, bus.cpu_rdata, bus.cpu_ack, vga_overrun} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.vga_data, bus.cpu_rdata, bus.cpu_ack, vga_overrun});
        end
`ifdef VRAM_ARB_STATS_EN
        vectors++;
        if (stall_count !== 16'd0) begin miscompares++; $display("FAIL reset_stall got %0d want 0", stall_count); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_vga_only();
        preload(13'h0123, 8'hA5);
        bus.vga_req = 1'b1; bus.vga_addr = 13'h0123;          // cycle T
        step();                                                // T+1
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.mem_addr !== 13'h0123 || bus.mem_we !== 1'b0) begin
            miscompares++; $display("FAIL vga_slot addr=%h we=%b want 0123/0", bus.mem_addr, bus.mem_we);
        end
        step();                                                // T+2
        vectors++;
        if (bus.vga_data !== 8'h00) begin miscompares++; $display("FAIL vga_early got %h want 00", bus.vga_data); end
        step();                                                // T+3
        vectors++;
        if (bus.vga_data !== 8'hA5) begin miscompares++; $display("FAIL vga_data got %h want a5", bus.vga_data); end
    endtask

    task automatic test_cpu_wr_rd();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1F00; bus.cpu_wdata = 8'h5A;  // R
        step();                                                                                 // R+1
        vectors++;
        if (bus.mem_addr !== 13'h1F00 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h5A) begin
            miscompares++; $display("FAIL cpu_wr_slot addr=%h we=%b wd=%h want 1f00/1/5a", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        step();                                                                                 // R+2
        vectors++;
        if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_wr_early_ack got %b want 0", bus.cpu_ack); end
        step();                                                                                 // R+3
        vectors++;
        if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("FAIL cpu_wr_ack got %b want 1", bus.cpu_ack); end
        bus.cpu_req = 1'b0;
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;                                                  // Q
        step();                                                                                 // Q+1
        vectors++;
        if (bus.mem_addr !== 13'h1F00 || bus.mem_we !== 1'b0) begin
            miscompares++; $display("FAIL cpu_rd_slot addr=%h we=%b want 1f00/0", bus.mem_addr, bus.mem_we);
        end
        step();
        step();                                                                                 // Q+3
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h5A) begin
            miscompares++; $display("FAIL cpu_rd_ack ack=%b rdata=%h want 1/5a", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
        vectors++;
        if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_ack_pulse got %b want 0", bus.cpu_ack); end
    endtask

    task automatic test_collision();
        do_reset();
        preload(13'h0010, 8'h3C);
        preload(13'h0040, 8'h77);
        bus.vga_req = 1'b1; bus.vga_addr = 13'h0040;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;   // C
        step();                                                           // C+1
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.mem_addr !== 13'h0040) begin miscompares++; $display("FAIL coll_vga_first got %h want 0040", bus.mem_addr); end
`ifdef VRAM_ARB_STATS_EN
        vectors++;
        if (stall_count !== 16'd1) begin miscompares++; $display("FAIL coll_stall got %0d want 1", stall_count); end
`endif
        step();                                                           // C+2
        vectors++;
        if (bus.mem_addr !== 13'h0010) begin miscompares++; $display("FAIL coll_cpu_next got %h want 0010", bus.mem_addr); end
        step();                                                           // C+3
        vectors++;
        if (bus.vga_data !== 8'h77 || bus.cpu_ack !== 1'b0) begin
            miscompares++; $display("FAIL coll_c3 vga=%h ack=%b want 77/0", bus.vga_data, bus.cpu_ack);
        end
        step();                                                           // C+4
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h3C) begin
            miscompares++; $display("FAIL coll_ack ack=%b rdata=%h want 1/3c", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
    endtask

    task automatic test_withdraw();
        step();
        bus.vga_req = 1'b1; bus.vga_addr = 13'h0055;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0020;
        step();
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (bus.cpu_ack !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'h0055) begin
                miscompares++;
                $display("FAIL withdraw_c%0d ack=%b we=%b addr=%h want 0/0/0055", i, bus.cpu_ack, bus.mem_we, bus.mem_addr);
            end
        end
    endtask

    task automatic test_overrun();
        preload(13'h000A, 8'h11);
        preload(13'h000B, 8'h22);
        bus.vga_req = 1'b1; bus.vga_addr = 13'h000A;   // O
        step();                                        // O+1
        bus.vga_addr = 13'h000B;
        vectors++;
        if (bus.mem_addr !== 13'h000A || vga_overrun !== 1'b0) begin
            miscompares++; $display("FAIL ovr_first addr=%h ovr=%b want 000a/0", bus.mem_addr, vga_overrun);
        end
        step();                                        // O+2
        bus.vga_req = 1'b0;
        vectors++;
        if (bus.mem_addr !== 13'h000B || vga_overrun !== 1'b1) begin
            miscompares++; $display("FAIL ovr_second addr=%h ovr=%b want 000b/1", bus.mem_addr, vga_overrun);
        end
        step();
        vectors++;
        if (bus.vga_data !== 8'h11) begin miscompares++; $display("FAIL ovr_data1 got %h want 11", bus.vga_data); end
        step();
        vectors++;
        if (bus.vga_data !== 8'h22) begin miscompares++; $display("FAIL ovr_data2 got %h want 22", bus.vga_data); end
        repeat (16) step();
        vectors++;
        if (vga_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", vga_overrun); end
    endtask

    task automatic test_reset_mid();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0321; bus.cpu_wdata = 8'hC3;
        step();
        vectors++;
        if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL rmid_slot we=%b want 1", bus.mem_we); end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.vga_data, bus.cpu_rdata, bus.cpu_ack, vga_overrun} !== 40'h0) begin
            miscompares++;
            $display("FAIL rmid_outputs got %h want 0", {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.vga_data, bus.cpu_rdata, bus.cpu_ack, vga_overrun});
        end
`ifdef VRAM_ARB_STATS_EN
        vectors++;
        if (stall_count !== 16'd0) begin miscompares++; $display("FAIL rmid_stall got %0d want 0", stall_count); end
`endif
        bus.cpu_req = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (bus.cpu_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
                miscompares++; $display("FAIL rmid_noack_c%0d ack=%b we=%b want 0/0", i, bus.cpu_ack, bus.mem_we);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] m_vga, m_rdata, c_wd;
        logic          m_ovr, prev_vga, c_we, cpu_act;
        logic [15:0]   m_stall;
        logic [AW-1:0] m_addr, c_addr;
        int            cpu_elig_k;

        do_reset();
        for (int a = 0; a < 32; a++) preload(a[AW-1:0], 8'($urandom));
        for (int k = 0; k < N + 8; k++) begin
            ev_vga[k] = 1'b0; ev_vval[k] = '0; ev_ack[k] = 1'b0; ev_rd[k] = 1'b0; ev_rdata[k] = '0;
            ev_ovr[k] = 1'b0; ev_stall[k] = 0; ev_slot[k] = 1'b0; ev_addr[k] = '0; ev_cpuwr[k] = 1'b0; ev_wdata[k] = '0;
        end
        m_vga = '0; m_rdata = '0; m_ovr = 1'b0; m_stall = '0; m_addr = '0;
        prev_vga = 1'b0; cpu_act = 1'b0; cpu_elig_k = 0;
        c_we = 1'b0; c_addr = '0; c_wd = '0;

        for (int k = 0; k < N; k++) begin
            // Events landing in this cycle.
            if (ev_vga[k]) m_vga = ev_vval[k];
            if (ev_ack[k] && ev_rd[k]) m_rdata = ev_rdata[k];
            if (ev_ovr[k]) m_ovr = 1'b1;
            m_stall = m_stall + 16'(ev_stall[k]);
            if (ev_slot[k]) m_addr = ev_addr[k];

            vectors++;
            if (bus.vga_data !== m_vga || bus.cpu_rdata !== m_rdata || bus.cpu_ack !== ev_ack[k]) begin
                miscompares++;
                $display("FAIL rnd_ret c%0d vga=%h rd=%h ack=%b want %h/%h/%b", k, bus.vga_data, bus.cpu_rdata, bus.cpu_ack, m_vga, m_rdata, ev_ack[k]);
            end
            vectors++;
            if (bus.mem_addr !== m_addr || bus.mem_we !== ev_cpuwr[k] || (ev_cpuwr[k] && bus.mem_wdata !== ev_wdata[k])) begin
                miscompares++;
                $display("FAIL rnd_mem c%0d addr=%h we=%b wd=%h want %h/%b/%h", k, bus.mem_addr, bus.mem_we, bus.mem_wdata, m_addr, ev_cpuwr[k], ev_wdata[k]);
            end
            vectors++;
            if (vga_overrun !== m_ovr) begin miscompares++; $display("FAIL rnd_ovr c%0d got %b want %b", k, vga_overrun, m_ovr); end
`ifdef VRAM_ARB_STATS_EN
            vectors++;
            if (stall_count !== m_stall) begin miscompares++; $display("FAIL rnd_stall c%0d got %0d want %0d", k, stall_count, m_stall); end
`endif

            // Stimulus for this cycle.
            bus.vga_req  = ($urandom_range(0, 99) < 20);
            bus.vga_addr = AW'($urandom_range(0, 31));
            if (cpu_act && k >= cpu_elig_k) cpu_act = 1'b0;            // ack seen or never issued: release below
            if (cpu_act && $urandom_range(0, 99) < 5) cpu_act = 1'b0;  // drop, possibly after issue
            if (!cpu_act && $urandom_range(0, 99) < 40) begin
                cpu_act = 1'b1;
                c_we    = $urandom_range(0, 1) == 1;
                c_addr  = AW'($urandom_range(0, 31));
                c_wd    = 8'($urandom);
            end
            bus.cpu_req = cpu_act; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;

            // Model: VGA owns the next slot outright; CPU gets it only once its previous access has fully retired.
            if (bus.vga_req) begin
                ev_slot[k+1] = 1'b1; ev_addr[k+1] = bus.vga_addr;
                ev_vga[k+3]  = 1'b1; ev_vval[k+3] = shadow[bus.vga_addr];
                if (prev_vga) ev_ovr[k+1] = 1'b1;
                if (cpu_act && k >= cpu_elig_k) ev_stall[k+1]++;
            end else if (cpu_act && k >= cpu_elig_k) begin
                ev_slot[k+1] = 1'b1; ev_addr[k+1] = c_addr; ev_cpuwr[k+1] = c_we; ev_wdata[k+1] = c_wd;
                ev_ack[k+3]  = 1'b1;
                cpu_elig_k   = k + 4;
                if (c_we) shadow[c_addr] = c_wd;
                else begin ev_rd[k+3] = 1'b1; ev_rdata[k+3] = shadow[c_addr]; end
            end
            prev_vga = bus.vga_req;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_vga_only();
        test_cpu_wr_rd();
        test_collision();
        test_withdraw();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB video RAM between the VGA character/graphics fetch and the 6502 CPU bus. The VGA fetch gets hard priority and a guaranteed fixed read latency, so the VGA generator can sample its data three cycles after raising its request. CPU reads and writes are slotted into the remaining cycles with a request/acknowledge handshake. Sits between the VGA generator, the CPU bus decoder (#8000–#9FFF region) and the video RAM block.

## Interface
Parameters:
- ADDR_W, 13, video RAM address width
- DATA_W, 8, data width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- vga_req  in  1  one-cycle fetch strobe from VGA generator
- vga_addr  in  ADDR_W  fetch address, valid while vga_req high
- vga_data  out  DATA_W  fetched byte, held until next VGA capture
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack high
- cpu_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address
- vga_overrun  out  1  sticky error flag
- stall_count  out  16  CPU cycles lost to VGA priority (only with VRAM_ARB_STATS_EN)

## Operation
- RAM port carries one access ("slot") per cycle; slot owner: SLOT_IDLE, SLOT_VGA, SLOT_CPU; registered return tag follows one cycle behind.
- Slot decision at each edge: vga_req=1 → SLOT_VGA (latch vga_addr, mem_we=0); else cpu_req=1 and CPU eligible → SLOT_CPU (latch cpu_addr, cpu_we, cpu_wdata); else SLOT_IDLE (mem_we=0, mem_addr holds).
- CPU eligible only when no CPU access is in flight and cpu_ack is not high this cycle.
- Return tag VGA → mem_rdata captured into vga_data. Tag CPU → mem_rdata captured into cpu_rdata (reads only; writes leave cpu_rdata unchanged), cpu_ack pulses next cycle.
- cpu_req dropped before its slot is issued → no access, no ack. Dropped after issue → access completes, ack still pulses.
- vga_req at an edge where current slot is SLOT_VGA → new fetch issued anyway, vga_overrun set; cleared only by reset.
- Simultaneous vga_req and eligible cpu_req → VGA wins; CPU issued at next edge if still eligible.
- Reset (any time, including mid-access): all outputs 0, slot SLOT_IDLE, tag cleared, in-flight CPU access abandoned without ack.

## Timing
- VGA: vga_req high in cycle T → slot VGA in T+1 → mem_rdata valid T+2 → vga_data valid from T+3. VGA generator raises req at phase 12 and samples at phase 15: exactly meets.
- CPU: slot in S → rdata valid S+1 → cpu_ack and cpu_rdata valid in S+2. Earliest next CPU slot S+4. Unstalled latency from cpu_req seen: 3 cycles.
- Worst-case CPU latency: one extra cycle per coinciding vga_req; vga_req at most every 16 cycles, so ≤4 cycles.

## Configuration
- VRAM_ARB_STATS_EN defined: stall_count increments (wrapping at 16 bits) on each edge where an eligible cpu_req loses to vga_req; reset to 0.
- Not defined: stall_count port absent, no counter logic.

## Structure
- Shared package: slot-owner enum (SLOT_IDLE/SLOT_VGA/SLOT_CPU), ADDR_W/DATA_W defaults, video RAM base constant #8000.
- Single module; no sub-module required. Counter under the macro stays inline.

## Test plan
- VGA only: vga_req pulse, vga_addr=0x0123, RAM[0x0123]=0xA5 → mem_addr=0x0123 next cycle, vga_data=0xA5 three cycles after req.
- CPU write then read: write 0x5A to 0x1F00, then read 0x1F00 → ack 3 cycles after each request, cpu_rdata=0x5A on read ack.
- Collision: vga_req and cpu_req (read 0x0010) in same cycle → VGA slot first, CPU slot next cycle, cpu_ack one cycle later than unstalled; vga_data timing unchanged; stall_count=1 with macro.
- Overrun: vga_req two consecutive cycles → both fetches issued, vga_overrun=1 and stays 1 until reset.
- Withdrawn request: cpu_req high one cycle coinciding with vga_req, then low → no CPU slot, no cpu_ack.
- Reset mid-access: assert reset during CPU slot → all outputs 0 immediately, no cpu_ack after release.
